// File: rtl/ram8.sv
// Eight-word synchronous-write register file with combinational read.
// A per-word dirty mask records which words were written since reset or clr.
module ram8 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic [DEPTH-1:0] dirty
);

  logic [WIDTH-1:0] word [DEPTH];
  logic [DEPTH-1:0] ld;

  // One-hot load routing; with load low the address is never used, so an
  // unknown address cannot select a word.
  always_comb begin
    // NOTE: default first so every path assigns ld and no latch is inferred.
    ld = '0;
    if (load) ld[address] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the words are reset explicitly because a cleared read value is
      // observable right after reset; this keeps them in flops, not a RAM macro.
      for (int k = 0; k < DEPTH; k++) word[k] <= '0;
      dirty <= '0;
    end else begin
      // NOTE: non-blocking so every word and the mask update from pre-edge values.
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k]) word[k] <= in;
      end
      dirty <= (dirty & ~{DEPTH{clr}}) | ld;
    end
  end

  assign out = word[address];

endmodule

// File: tb/tb_ram8.sv
// Scoreboard bench for ram8: stimulus queues expectations, a monitor process
// samples the DUT on each request strobe and compares.
module tb_ram8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic [2:0]  address = '0;
  logic        clr = 1'b0;
  logic [15:0] out;
  logic [7:0]  dirty;

  typedef struct {
    string       name;
    bit          is_dirty;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  bit   sample_tgl = 1'b0;
  int   total = 0;
  int   bad = 0;

  ram8 #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load),
    .address(address), .clr(clr), .out(out), .dirty(dirty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h want 0x%04h", name, act, exp);
    end
  endtask

  // Monitor: drains every queued expectation when the stimulus raises a sample request.
  always @(sample_tgl) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.is_dirty) check(e.name, {8'h00, dirty}, e.val);
      else            check(e.name, out, e.val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string name, input logic [2:0] a, input logic [15:0] v);
    address = a;
    #1;
    sb.push_back('{name, 1'b0, v});
    sample_tgl = ~sample_tgl;
    #1;
  endtask

  task automatic exp_dirty(input string name, input logic [7:0] v);
    sb.push_back('{name, 1'b1, {8'h00, v}});
    sample_tgl = ~sample_tgl;
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  logic [7:0]  routing_dirty [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
  logic [15:0] routing_data  [8] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                                     16'h1004, 16'h1005, 16'h1006, 16'h1007};
  logic [15:0] fill_data     [8] = '{16'h2000, 16'h2001, 16'h2002, 16'h2003,
                                     16'h2004, 16'h2005, 16'h2006, 16'h2007};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random traffic on the write port.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in      = 16'($urandom);
      load    = 1'($urandom);
      address = 3'($urandom);
      tick();
    end
    load  = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) exp_out("reset_out", 3'(a), 16'h0000);
    exp_dirty("reset_dirty", 8'h00);

    // Routing: one write per cycle, mask grows by one bit each edge.
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      in      = routing_data[k];
      load    = 1'b1;
      tick();
      load    = 1'b0;
      exp_dirty("route_dirty", routing_dirty[k]);
    end
    for (int a = 0; a < 8; a++) exp_out("route_read", 3'(a), routing_data[a]);

    // Clear only the mask, then hold a single written word.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_dirty("clr_dirty", 8'h00);
    exp_out("clr_keeps_data", 3'd2, 16'h1002);
    write(3'd5, 16'hBEEF);
    for (int i = 0; i < 10; i++) begin
      in      = 16'($urandom);
      address = 3'($urandom);
      tick();
    end
    exp_out("hold_word5", 3'd5, 16'hBEEF);
    exp_dirty("hold_dirty", 8'h20);
    exp_out("hold_word4", 3'd4, 16'h1004);

    // Same-cycle read and write of address 3.
    write(3'd3, 16'h0001);
    address = 3'd3;
    in      = 16'hAAAA;
    load    = 1'b1;
    #1;
    exp_out("rw_before_edge", 3'd3, 16'h0001);
    tick();
    load = 1'b0;
    exp_out("rw_after_edge", 3'd3, 16'hAAAA);

    // Fill every word so the mask is full, then collide clr with a write.
    for (int k = 0; k < 8; k++) write(3'(k), fill_data[k]);
    exp_dirty("fill_dirty", 8'hFF);
    address = 3'd6;
    in      = 16'h6666;
    load    = 1'b1;
    clr     = 1'b1;
    tick();
    load = 1'b0;
    clr  = 1'b0;
    exp_dirty("collide_dirty", 8'h40);
    for (int a = 0; a < 8; a++)
      exp_out("collide_read", 3'(a), (a == 6) ? 16'h6666 : fill_data[a]);
    write(3'd6, 16'h7777);
    write(3'd6, 16'h8888);
    exp_out("last_write_wins", 3'd6, 16'h8888);
    exp_dirty("rewrite_dirty", 8'h40);

    // Asynchronous reset between edges.
    for (int k = 0; k < 8; k++) write(3'(k), 16'hFFFF);
    exp_out("ones_before_rst", 3'd2, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_out("async_rst_out", 3'd2, 16'h0000);
    exp_dirty("async_rst_dirty", 8'h00);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) exp_out("post_rst_read", 3'(a), 16'h0000);

    // A write whose edge coincides with reset is lost.
    address = 3'd1;
    in      = 16'h1234;
    load    = 1'b1;
    rst_n   = 1'b0;
    tick();
    load  = 1'b0;
    rst_n = 1'b1;
    exp_out("write_under_rst", 3'd1, 16'h0000);
    exp_dirty("dirty_under_rst", 8'h00);

    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
